hdmi_period_sched: RTL
======================

Name: hdmi_period_sched

Overview:
- Scheduler and timing controller for the three-channel TMDS encoder datapath.
- Generates raster position, sync, and the per-pixel period type: control, video preamble, video guard band or active video.
- Drives VDE/CD inputs of the encoders plus a guard-band select for the channel output muxes.
- Runs in the pixel clock domain; adds start/stop frame sequencing so the link never emits a truncated frame.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- CW, 12, counter / coordinate width

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-low
- run  in  1  request video output; level-sensitive
- busy  out  1  FSM not in IDLE
- frame_start  out  1  one-cycle pulse with pixel (0,0) of each frame
- pix_req  out  1  next cycle is an active pixel; pixel source latches colour now
- pix_x  out  CW  x of the pixel requested by pix_req
- pix_y  out  CW  y of the pixel requested by pix_req
- vde  out  1  video data enable to all encoders
- guard  out  1  video guard band; output mux substitutes guard codes
- cd0  out  2  {vsync,hsync} to channel 0 encoder
- cd1  out  2  {CTL1,CTL0} to channel 1 encoder
- cd2  out  2  {CTL3,CTL2} to channel 2 encoder

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Internal counters hx, vy. hx wraps H_TOTAL-1→0 and then increments vy; vy wraps V_TOTAL-1→0.
- All outputs are registered and are functions of the same (hx,vy) from the previous cycle. Latency counter→output is exactly 1 clk.
- vde = (hx<H_ACTIVE)&&(vy<V_ACTIVE).
- hsync active for H_ACTIVE+H_FP ≤ hx < H_ACTIVE+H_FP+H_SYNC; vsync analogous on vy.
- Output syncs use HS_POL/VS_POL; inactive level is the complement.
- nxt_active: the following line is an active line, i.e. vy<V_ACTIVE-1 or vy==V_TOTAL-1.
- Preamble: hx in [H_TOTAL-10, H_TOTAL-3] with nxt_active. cd1=2'b01, cd2=2'b00; otherwise cd1=cd2=2'b00.
- Guard: hx in [H_TOTAL-2, H_TOTAL-1] with nxt_active. guard=1, vde=0.
- Preamble/guard never overlap hsync. Requires H_FP+H_SYNC+H_BP ≥ 22 so that ≥12 control-period clocks precede the preamble; elaboration error otherwise.
- pix_req/pix_x/pix_y: asserted one cycle before vde rises, for the same pixel that vde presents next cycle.
- FSM states:
  - IDLE: hx=vy=0 held; outputs in control period, syncs inactive; vde=guard=0, cd1=cd2=0.
  - RUN: counters advance every clk.
  - STOP: counters advance; finishing current frame.
- Transitions:
  - IDLE→RUN when run=1. First counter advance is the next cycle; frame_start pulses aligned to pixel (0,0) output.
  - RUN→STOP when run=0.
  - STOP→RUN if run returns to 1 before frame end; no visible discontinuity.
  - STOP→IDLE at hx=H_TOTAL-1, vy=V_TOTAL-1.
- STOP behaviour: on the last line (vy==V_TOTAL-1), preamble and guard are suppressed. No orphan guard band is emitted before an idle link.
- frame_start pulses only on frames actually output, in RUN or STOP.
- Reset values (async, any time including mid-frame): state=IDLE, hx=vy=0, vde=guard=pix_req=frame_start=busy=0, cd1=cd2=0, cd0={~VS_POL,~HS_POL}, pix_x=pix_y=0.

Optional Feature:
- Macro: HDMI_PERIOD_SCHED_PREAMBLE_EN.
- Defined: preamble and guard-band generation as above (HDMI mode).
- Undefined (DVI mode): guard tied 0, cd1=cd2 tied 2'b00, 22-clock blanking check removed. All other timing identical.

Test Plan:
- Reset, run=1 at defaults:
  - frame_start first seen 2 cycles after run sampled high.
  - vde high for 640 clks per line, 480 lines.
  - Period 800×525 = 420000 clks between frame_start pulses.
- hsync check (HS_POL=0):
  - cd0[0]=0 exactly for output hx 656..751 (96 clks).
  - vsync cd0[1]=0 exactly on vy 490..491.
- Preamble/guard on line before row 0 and rows 0..478 (macro defined):
  - cd1=01 for hx 790..797, guard=1 for hx 798..799, vde rises on the next cycle.
  - Row 479 line end shows neither.
- Deassert run mid-frame at (100,200):
  - Frame completes; busy falls after output (799,524).
  - No guard on the last line; stays idle with syncs inactive.
- Re-assert run during STOP at line 300: no gap, next frame_start exactly 420000 clks after previous.
- Assert rst low at hx=700, vy=10, and separately with macro undefined:
  - All outputs at reset values immediately.
  - Undefined build never asserts guard or nonzero cd1/cd2.

Source files
------------

// File: rtl/hdmi_period_sched.sv
// hdmi_period_sched: raster position, sync and TMDS period scheduler (control/preamble/guard/video)
// Ports: clk pixel clock; rst async active-low; run level request for video output;
//   busy FSM not idle; frame_start pulse with pixel (0,0); pix_req/pix_x/pix_y pixel fetch
//   one cycle ahead of vde; vde video enable; guard guard-band select; cd0 {vsync,hsync};
//   cd1 {CTL1,CTL0}; cd2 {CTL3,CTL2}.
// Build option: define HDMI_PERIOD_SCHED_PREAMBLE_EN for HDMI preamble/guard generation,
//   leave undefined for DVI (guard and CTL lines held at zero).
module hdmi_period_sched #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic          busy,
    output logic          frame_start,
    output logic          pix_req,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          vde,
    output logic          guard,
    output logic [1:0]    cd0,
    output logic [1:0]    cd1,
    output logic [1:0]    cd2
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CW-1:0] HA  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS0 = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS1 = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] HT1 = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] VA  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VS0 = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS1 = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] VT1 = CW'(V_TOTAL - 1);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] hx, vy, hx_n, vy_n;
    logic          on, h_end, v_end, req_n, vis, hs_act, vs_act, pre, grd;

    // STOP keeps scanning so a frame is never cut short; it may only drop to IDLE
    // on the very last pixel, or resume RUN at any point without a gap.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = run ? RUN : IDLE;
            RUN:     state_n = run ? RUN : STOP;
            default: state_n = run ? RUN : (h_end && v_end) ? IDLE : STOP;
        endcase
    end

    assign on     = state != IDLE;
    assign h_end  = hx == HT1;
    assign v_end  = vy == VT1;
    assign hx_n   = (!on || h_end) ? '0 : hx + 1'b1;
    assign vy_n   = (!on || (h_end && v_end)) ? '0 : h_end ? vy + 1'b1 : vy;
    // pix_req looks at the position the counters take next, so the source has one
    // cycle to present colour before vde shows that same pixel.
    assign req_n  = state_n != IDLE && hx_n < HA && vy_n < VA;
    assign vis    = on && hx < HA && vy < VA;
    assign hs_act = on && hx >= HS0 && hx < HS1;
    assign vs_act = on && vy >= VS0 && vy < VS1;

`ifdef HDMI_PERIOD_SCHED_PREAMBLE_EN
    localparam logic [CW-1:0] HP0 = CW'(H_TOTAL - 10);
    localparam logic [CW-1:0] HP1 = CW'(H_TOTAL - 3);
    localparam logic [CW-1:0] HG0 = CW'(H_TOTAL - 2);
    localparam logic [CW-1:0] VA1 = CW'(V_ACTIVE - 1);

    // 8 preamble + 2 guard clocks must sit after at least 12 control clocks in blanking.
    if (H_FP + H_SYNC + H_BP < 22) begin : g_blank_chk
        $error("hdmi_period_sched: horizontal blanking must be at least 22 clocks");
    end

    logic nxt_active, ctl_en;

    // Preamble/guard announce the next line's video; while stopping, the last line
    // has no successor frame so nothing is announced there.
    always_comb begin
        nxt_active = vy < VA1 || v_end;
        ctl_en     = on && nxt_active && !(state == STOP && v_end);
        pre        = ctl_en && hx >= HP0 && hx <= HP1;
        grd        = ctl_en && hx >= HG0;
    end
`else
    assign pre = 1'b0;
    assign grd = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            hx          <= '0;
            vy          <= '0;
            busy        <= 1'b0;
            frame_start <= 1'b0;
            pix_req     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            vde         <= 1'b0;
            guard       <= 1'b0;
            cd0         <= {~VS_POL, ~HS_POL};
            cd1         <= 2'b00;
            cd2         <= 2'b00;
        end else begin
            state       <= state_n;
            hx          <= hx_n;
            vy          <= vy_n;
            busy        <= on;
            frame_start <= on && hx == '0 && vy == '0;
            pix_req     <= req_n;
            pix_x       <= req_n ? hx_n : '0;
            pix_y       <= req_n ? vy_n : '0;
            vde         <= vis && !grd;
            guard       <= grd;
            cd0         <= {vs_act ? VS_POL : ~VS_POL, hs_act ? HS_POL : ~HS_POL};
            cd1         <= {1'b0, pre};
            cd2         <= 2'b00;
        end
    end
endmodule
